// File: rtl/fetch_issue_queue_pkg.sv
// Shared pipeline definitions for the fetch/issue instruction queue:
// default widths, PC step and the circular lane-index helper.
package fetch_issue_queue_pkg;

  localparam int IW_DEF  = 32;
  localparam int AW_DEF  = 32;
  localparam int PC_STEP = 4;

  // Slot holding lane i when the window starts at ptr; depth is a power of two.
  function automatic int unsigned lane_idx(input int unsigned ptr,
                                           input int unsigned i,
                                           input int unsigned depth);
    return (ptr + i) & (depth - 1);
  endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Fetch-to-issue bundle interface. Fetch offers a bundle with in_valid and it is
// taken on an edge where in_ready is high; issue reports consumed lanes via out_accept.
interface fetch_issue_queue_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int AW    = 32
);
  localparam int CW = $clog2(LANES + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [CW-1:0]       in_count;
  logic [AW-1:0]       in_pc;
  logic [LANES*IW-1:0] in_instr;
  logic [LANES-1:0]    out_valid;
  logic [LANES*IW-1:0] out_instr;
  logic [LANES*AW-1:0] out_pc;
  logic [CW-1:0]       out_accept;
  logic [OW-1:0]       occupancy;

  modport master (
    output flush, in_valid, in_count, in_pc, in_instr, out_accept,
    input  in_ready, out_valid, out_instr, out_pc, occupancy
  );

  modport slave (
    input  flush, in_valid, in_count, in_pc, in_instr, out_accept,
    output in_ready, out_valid, out_instr, out_pc, occupancy
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x W register array with LANES independent write ports and
// LANES asynchronous read ports for the instruction queue.
module fetch_queue_ram #(
  parameter  int LANES = 2,
  parameter  int DEPTH = 8,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [LANES-1:0]          wr_en,
  input  logic [LANES-1:0][PW-1:0]  wr_addr,
  input  logic [LANES-1:0][W-1:0]   wr_data,
  input  logic [LANES-1:0][PW-1:0]  rd_addr,
  output logic [LANES-1:0][W-1:0]   rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write addresses of one bundle are always distinct slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/fetch_issue_queue.sv
// Circular instruction queue between fetch and decode: bundle push, 0..LANES
// in-order pops per cycle, and a front-end flush.
module fetch_issue_queue
  import fetch_issue_queue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int IW    = IW_DEF,
  parameter int AW    = AW_DEF
) (
  input logic               clk,
  input logic               reset,
  fetch_issue_queue_if.slave bus
);

  localparam int CW = $clog2(LANES + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = IW + AW;

  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [OW-1:0]             occ;
  logic                      ready;
  logic                      push;
  logic [CW-1:0]             n_w;
  logic [CW-1:0]             n_r;
  logic                      lane_on;
  logic [LANES-1:0]          wr_en;
  logic [LANES-1:0][PW-1:0]  wr_addr;
  logic [LANES-1:0][PW-1:0]  rd_addr;
  logic [LANES-1:0][EW-1:0]  wr_data;
  logic [LANES-1:0][EW-1:0]  rd_data;

  // Accept only when a full bundle fits, independent of this cycle's pops.
  always_comb begin
    ready = reset && (occ <= OW'(DEPTH - LANES));
    push  = bus.in_valid && ready && !bus.flush;
    n_w   = '0;
    if (push) n_w = (bus.in_count > CW'(LANES)) ? CW'(LANES) : bus.in_count;
    // Over-accept is clamped so the queue never underflows.
    n_r   = '0;
    if (!bus.flush) n_r = (OW'(bus.out_accept) > occ) ? CW'(occ) : bus.out_accept;
  end

  always_comb begin
    lane_on       = 1'b0;
    wr_en         = '0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_addr       = '0;
    bus.out_valid = '0;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_en[i]   = push && (i < int'(n_w));
      wr_addr[i] = PW'(lane_idx(int'(wr_ptr), i, DEPTH));
      wr_data[i] = {bus.in_pc + AW'(PC_STEP * i), bus.in_instr[i*IW +: IW]};
      rd_addr[i] = PW'(lane_idx(int'(rd_ptr), i, DEPTH));
      lane_on    = i < int'(occ);
      bus.out_valid[i]         = lane_on;
      bus.out_instr[i*IW +: IW] = lane_on ? rd_data[i][IW-1:0] : '0;
      bus.out_pc[i*AW +: AW]    = lane_on ? rd_data[i][IW +: AW] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_r);
      wr_ptr <= wr_ptr + PW'(n_w);
      occ    <= occ + OW'(n_w) - OW'(n_r);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.occupancy = occ;

  fetch_queue_ram #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .W     (EW)
  ) ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Self-checking bench for fetch_issue_queue: directed scenarios plus randomized
// push/accept traffic against a queue-based reference model.
module tb_fetch_issue_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int CW    = $clog2(LANES + 1);
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int EW    = IW + AW;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   total_written = 0;
  logic [EW-1:0] exp_q[$];

  fetch_issue_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .IW(IW), .AW(AW)) bus();

  fetch_issue_queue #(.LANES(LANES), .DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int cnt, input logic [AW-1:0] pc,
                       input logic [LANES*IW-1:0] instrs, input int acc, input logic fl);
    bus.in_valid   = v;
    bus.in_count   = CW'(cnt);
    bus.in_pc      = pc;
    bus.in_instr   = instrs;
    bus.out_accept = CW'(acc);
    bus.flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, '0, 0, 1'b0);
  endtask

  // One clock edge; the reference model applies the queue rules to the
  // inputs present at that edge, then control returns on the falling edge.
  task automatic tick();
    int  nr;
    int  nw;
    bit  rdy;
    @(posedge clk);
    if (!reset || bus.flush) begin
      exp_q.delete();
    end else begin
      rdy = exp_q.size() <= DEPTH - LANES;
      nr  = (int'(bus.out_accept) > exp_q.size()) ? exp_q.size() : int'(bus.out_accept);
      repeat (nr) void'(exp_q.pop_front());
      if (bus.in_valid && rdy) begin
        nw = (int'(bus.in_count) > LANES) ? LANES : int'(bus.in_count);
        for (int i = 0; i < nw; i++)
          exp_q.push_back({bus.in_pc + AW'(4 * i), bus.in_instr[i*IW +: IW]});
        total_written += nw;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    drive(1'b0, 0, '0, '0, 0, 1'b1);
    tick();
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 2, 32'h40, {32'h2222_2222, 32'h1111_1111}, 0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready);
    end
    tick();
    tick();
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_held got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.occupancy !== OW'(0)) begin
      errors++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy);
    end
    reset = 1'b1;
    idle();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 2'b00 || bus.out_instr !== '0 || bus.out_pc !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs valid=%b instr=%h pc=%h exp all zero",
               bus.out_valid, bus.out_instr, bus.out_pc);
    end
  endtask

  task automatic test_basic_push();
    drive(1'b1, 2, 32'h100, {32'hBBBB_0002, 32'hAAAA_0001}, 0, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.out_valid !== 2'b11) begin
      errors++; $display("FAIL push_valid got=%b exp=11", bus.out_valid);
    end
    checks++;
    if (bus.out_pc !== {32'h104, 32'h100}) begin
      errors++; $display("FAIL push_pc got=%h exp=%h", bus.out_pc, {32'h104, 32'h100});
    end
    checks++;
    if (bus.out_instr !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
      errors++; $display("FAIL push_instr got=%h exp=bbbb0002aaaa0001", bus.out_instr);
    end
    checks++;
    if (bus.occupancy !== OW'(2)) begin
      errors++; $display("FAIL push_occupancy got=%0d exp=2", bus.occupancy);
    end
  endtask

  task automatic test_split_issue();
    drive(1'b1, 1, 32'h108, {32'hFFFF_FFFF, 32'hCCCC_0003}, 0, 1'b0);
    tick();
    drive(1'b0, 0, '0, '0, 1, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.out_instr !== {32'hCCCC_0003, 32'hBBBB_0002} || bus.out_pc !== {32'h108, 32'h104}) begin
      errors++;
      $display("FAIL split_lanes instr=%h pc=%h exp instr=cccc0003bbbb0002 pc=0000010800000104",
               bus.out_instr, bus.out_pc);
    end
    checks++;
    if (bus.occupancy !== OW'(2)) begin
      errors++; $display("FAIL split_occupancy got=%0d exp=2", bus.occupancy);
    end
    do_flush();
  endtask

  task automatic test_odd_bundle();
    drive(1'b1, 1, 32'h200, {32'hDEAD_BEEF, 32'hDDDD_0004}, 0, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.out_valid !== 2'b01) begin
      errors++; $display("FAIL odd_valid got=%b exp=01", bus.out_valid);
    end
    checks++;
    if (bus.out_instr !== {32'h0, 32'hDDDD_0004} || bus.out_pc !== {32'h0, 32'h200}) begin
      errors++;
      $display("FAIL odd_lanes instr=%h pc=%h exp instr=00000000dddd0004 pc=0000000000000200",
               bus.out_instr, bus.out_pc);
    end
    do_flush();
  endtask

  task automatic test_full_backpressure();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2, 32'h400 + 32'(8 * k), {32'(k * 2 + 1), 32'(k * 2)}, 0, 1'b0);
      tick();
    end
    idle();
    #1;
    checks++;
    if (bus.occupancy !== OW'(8) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state occ=%0d ready=%b exp occ=8 ready=0", bus.occupancy, bus.in_ready);
    end
    drive(1'b1, 2, 32'h500, {32'h55, 32'h54}, 0, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.occupancy !== OW'(8) || bus.out_pc[AW-1:0] !== 32'h400) begin
      errors++;
      $display("FAIL full_ignore occ=%0d pc0=%h exp occ=8 pc0=400", bus.occupancy, bus.out_pc[AW-1:0]);
    end
    drive(1'b0, 0, '0, '0, 2, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.occupancy !== OW'(6) || bus.in_ready !== 1'b1 || bus.out_pc[AW-1:0] !== 32'h408) begin
      errors++;
      $display("FAIL full_drain occ=%0d ready=%b pc0=%h exp occ=6 ready=1 pc0=408",
               bus.occupancy, bus.in_ready, bus.out_pc[AW-1:0]);
    end
    do_flush();
  endtask

  task automatic test_random_wrap();
    logic [LANES-1:0]    e_valid;
    logic [LANES*IW-1:0] e_instr;
    logic [LANES*AW-1:0] e_pc;
    int start_written;
    start_written = total_written;
    for (int c = 0; c < 60; c++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, LANES), AW'($urandom),
            {IW'($urandom), IW'($urandom)}, $urandom_range(0, LANES), 1'b0);
      tick();
      idle();
      #1;
      e_valid = '0;
      e_instr = '0;
      e_pc    = '0;
      for (int i = 0; i < LANES; i++) begin
        if (i < exp_q.size()) begin
          e_valid[i]          = 1'b1;
          e_instr[i*IW +: IW] = exp_q[i][IW-1:0];
          e_pc[i*AW +: AW]    = exp_q[i][IW +: AW];
        end
      end
      checks++;
      if (bus.occupancy !== OW'(exp_q.size()) ||
          bus.in_ready !== (exp_q.size() <= DEPTH - LANES)) begin
        errors++;
        $display("FAIL rand_state cyc=%0d occ=%0d ready=%b exp occ=%0d ready=%b", c,
                 bus.occupancy, bus.in_ready, exp_q.size(), exp_q.size() <= DEPTH - LANES);
      end
      checks++;
      if (bus.out_valid !== e_valid || bus.out_instr !== e_instr || bus.out_pc !== e_pc) begin
        errors++;
        $display("FAIL rand_lanes cyc=%0d valid=%b instr=%h pc=%h exp valid=%b instr=%h pc=%h",
                 c, bus.out_valid, bus.out_instr, bus.out_pc, e_valid, e_instr, e_pc);
      end
    end
    checks++;
    if (total_written - start_written < 3 * DEPTH) begin
      errors++;
      $display("FAIL rand_wrap_coverage got=%0d entries exp>=%0d", total_written - start_written, 3 * DEPTH);
    end
    do_flush();
  endtask

  task automatic test_flush();
    drive(1'b1, 2, 32'h600, {32'h61, 32'h60}, 0, 1'b0);
    tick();
    drive(1'b1, 2, 32'h680, {32'h69, 32'h68}, 1, 1'b1);
    tick();
    idle();
    #1;
    checks++;
    if (bus.occupancy !== OW'(0) || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state occ=%0d valid=%b ready=%b exp occ=0 valid=00 ready=1",
               bus.occupancy, bus.out_valid, bus.in_ready);
    end
    drive(1'b1, 1, 32'h700, {32'h0, 32'h70}, 0, 1'b0);
    tick();
    idle();
    #1;
    checks++;
    if (bus.occupancy !== OW'(1) || bus.out_pc[AW-1:0] !== 32'h700 || bus.out_instr[IW-1:0] !== 32'h70) begin
      errors++;
      $display("FAIL flush_refill occ=%0d pc0=%h instr0=%h exp occ=1 pc0=700 instr0=70",
               bus.occupancy, bus.out_pc[AW-1:0], bus.out_instr[IW-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2, 32'h800, {32'h81, 32'h80}, 0, 1'b0);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.occupancy !== OW'(exp_q.size()) || bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid occ=%0d valid=%b exp occ=%0d valid=00",
               bus.occupancy, bus.out_valid, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_basic_push();
    test_split_issue();
    test_odd_bundle();
    test_full_backpressure();
    test_random_wrap();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
